// File: rtl/channel_ctrl_if.sv
// Event read-out port between a channel controller and the event router.
// Carries the FIFO head word with a valid/ready handshake.
//   event_data  : {timestamp, ADC code} at the FIFO head
//   event_valid : FIFO holds at least one word
//   event_ready : consumer accepts the head word this cycle
// master = channel controller, slave = event router.
interface channel_ctrl_if #(
  parameter int unsigned DATA_W = 34
);
  logic [DATA_W-1:0] event_data;
  logic              event_valid;
  logic              event_ready;

  modport master (output event_data, output event_valid, input event_ready);
  modport slave  (input event_data, input event_valid, output event_ready);
endinterface

// File: rtl/channel_ctrl.sv
// Per-channel controller for one analog channel (CSA, discriminator, SAR ADC).
// A synchronised hit latches the timestamp, waits hold_delay+1 cycles, pulses
// sample for sample_cycles+1 cycles, waits for the ADC done, stores
// {timestamp, code} in a small FWFT FIFO and re-arms the CSA with a
// reset_cycles+1 cycle csa_reset pulse.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   hit, done, dout     : analog-core inputs (hit/done asynchronous)
//   enable              : channel enable, honoured only while idle
//   hold_delay, sample_cycles, reset_cycles : timing, each encoded minus 1
//   timestamp           : free-running time counter
//   sample, csa_reset   : analog-core controls
//   evt                 : event FIFO head, valid/ready handshake
//   fifo_count          : FIFO occupancy
//   overflow, timeout_err, clear_flags : sticky error flags and their clear
module channel_ctrl #(
  parameter int unsigned ADCBITS      = 10,
  parameter int unsigned TS_BITS      = 24,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CONV_TIMEOUT = 63
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          hit,
  input  logic                          done,
  input  logic [ADCBITS-1:0]            dout,
  input  logic                          enable,
  input  logic [3:0]                    hold_delay,
  input  logic [3:0]                    sample_cycles,
  input  logic [3:0]                    reset_cycles,
  input  logic [TS_BITS-1:0]            timestamp,
  output logic                          sample,
  output logic                          csa_reset,
  channel_ctrl_if.master                evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout_err,
  input  logic                          clear_flags
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = TS_BITS + ADCBITS;
  localparam int unsigned TW = $clog2(CONV_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    SAMPLE  = 3'd2,
    CONVERT = 3'd3,
    STORE   = 3'd4,
    CSARST  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [TS_BITS-1:0]   ts_q, ts_d;
  logic [ADCBITS-1:0]   dout_q, dout_d;
  logic                 sample_d, csa_reset_d;
  logic                 push, timeout_set;

  logic                 hit_m, hit_s, done_m, done_s;

  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_d;
  logic                 valid_q;
  logic                 full, pop, push_ok, drop;

  // Two-flop synchronisers for the asynchronous analog-core strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_m  <= 1'b0;
      hit_s  <= 1'b0;
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      hit_m  <= hit;
      hit_s  <= hit_m;
      done_m <= done;
      done_s <= done_m;
    end
  end

  // FSM state and registered analog controls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CSARST;
      cnt_q     <= reset_cycles;
      tcnt_q    <= '0;
      ts_q      <= '0;
      dout_q    <= '0;
      sample    <= 1'b0;
      csa_reset <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      ts_q      <= ts_d;
      dout_q    <= dout_d;
      sample    <= sample_d;
      csa_reset <= csa_reset_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they are
  // registered alongside it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    ts_d        = ts_q;
    dout_d      = dout_q;
    push        = 1'b0;
    timeout_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && hit_s) begin
          ts_d    = timestamp;
          cnt_d   = hold_delay;
          state_d = HOLD;
        end else if (enable && csa_reset) begin
          // csa_reset still high in IDLE means the channel was masked:
          // re-arm with a full CSA reset pulse before accepting hits.
          cnt_d   = reset_cycles;
          state_d = CSARST;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = sample_cycles;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        if (cnt_q == 4'd0) begin
          tcnt_d  = '0;
          state_d = CONVERT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CONVERT: begin
        if (done_s) begin
          dout_d  = dout;
          state_d = STORE;
        end else if (tcnt_q == TW'(CONV_TIMEOUT)) begin
          timeout_set = 1'b1;
          cnt_d       = reset_cycles;
          state_d     = CSARST;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      STORE: begin
        push    = 1'b1;
        cnt_d   = reset_cycles;
        state_d = CSARST;
      end
      CSARST: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        cnt_d   = reset_cycles;
        state_d = CSARST;
      end
    endcase

    sample_d    = (state_d == SAMPLE);
    csa_reset_d = (state_d == CSARST) || ((state_d == IDLE) && !enable);
  end

  // FIFO control: a push while full only succeeds if a pop frees a slot
  // in the same cycle.
  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign pop     = valid_q && evt.event_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign count_d = fifo_count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem        <= '{default: '0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {ts_q, dout_q};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= count_d;
      valid_q    <= (count_d != '0);
    end
  end

  assign evt.event_data  = mem[rd_ptr];
  assign evt.event_valid = valid_q;

  // Sticky error flags; a new set wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop)             overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (timeout_set)      timeout_err <= 1'b1;
      else if (clear_flags) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_channel_ctrl.sv
// Directed bench for channel_ctrl: a per-cycle vector table for a single
// event plus hand-written sequences for reset, timeout, masking, overflow
// and full-with-simultaneous-pop.
module tb_channel_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hit, done, enable, clear_flags;
  logic [9:0]  dout;
  logic [3:0]  hold_delay, sample_cycles, reset_cycles;
  logic [23:0] timestamp;
  logic        sample, csa_reset, overflow, timeout_err;
  logic [2:0]  fifo_count;

  int n_pass  = 0;
  int n_total = 0;

  channel_ctrl_if #(.DATA_W(34)) evt_if ();

  channel_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hit           (hit),
    .done          (done),
    .dout          (dout),
    .enable        (enable),
    .hold_delay    (hold_delay),
    .sample_cycles (sample_cycles),
    .reset_cycles  (reset_cycles),
    .timestamp     (timestamp),
    .sample        (sample),
    .csa_reset     (csa_reset),
    .evt           (evt_if),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .timeout_err   (timeout_err),
    .clear_flags   (clear_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic       done;
    logic       exp_sample;
    logic       exp_csa;
    logic       exp_valid;
    logic [2:0] exp_count;
  } vec_t;

  vec_t        tbl[20];
  logic [33:0] exp_words[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return sample;
      1:       return csa_reset;
      default: return timeout_err;
    endcase
  endfunction

  // Bounded wait for a DUT output to reach a level.
  task automatic wait_sig(input int which, input logic val, input string name);
    int n;
    n = 0;
    while (sel(which) !== val && n < 200) begin
      tick();
      n++;
    end
    chk(name, 64'(sel(which) === val), 64'd1);
  endtask

  task automatic fire_hit();
    hit = 1'b1;
    repeat (3) tick();
    hit = 1'b0;
  endtask

  // One complete event; done is raised two cycles after sample falls and
  // reaches the FSM two cycles later, so STORE acts on the fourth edge.
  task automatic run_event(input logic [23:0] ts, input logic [9:0] code, input bit pop_at_store);
    timestamp = ts;
    fire_hit();
    wait_sig(0, 1'b1, "ev_sample_rise");
    wait_sig(0, 1'b0, "ev_sample_fall");
    tick();
    tick();
    done = 1'b1;
    dout = code;
    repeat (3) tick();
    if (pop_at_store) evt_if.event_ready = 1'b1;
    tick();
    evt_if.event_ready = 1'b0;
    chk("ev_store_csa", 64'(csa_reset), 64'd1);
    done = 1'b0;
    wait_sig(1, 1'b0, "ev_rearm");
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4; i++) begin
      chk({name, "_valid"}, 64'(evt_if.event_valid), 64'd1);
      chk({name, "_data"}, 64'(evt_if.event_data), 64'(exp_words[i]));
      evt_if.event_ready = 1'b1;
      tick();
      evt_if.event_ready = 1'b0;
    end
    chk({name, "_empty_valid"}, 64'(evt_if.event_valid), 64'd0);
    chk({name, "_empty_count"}, 64'(fifo_count), 64'd0);
  endtask

  initial begin
    int n;

    // Single-event vectors: row k is applied before edge k+1, checked after it.
    for (int k = 1; k <= 20; k++) begin
      tbl[k-1].hit        = (k <= 3);
      tbl[k-1].done       = (k >= 15) && (k <= 18);
      tbl[k-1].exp_sample = (k >= 6) && (k <= 9);
      tbl[k-1].exp_csa    = (k == 18) || (k == 19);
      tbl[k-1].exp_valid  = (k >= 18);
      tbl[k-1].exp_count  = (k >= 18) ? 3'd1 : 3'd0;
    end

    reset_n = 1'b0;
    hit = 1'b0;
    done = 1'b0;
    dout = '0;
    enable = 1'b1;
    clear_flags = 1'b0;
    hold_delay = 4'd2;
    sample_cycles = 4'd3;
    reset_cycles = 4'd1;
    timestamp = '0;
    evt_if.event_ready = 1'b0;

    // Reset values and post-reset CSA pulse.
    repeat (3) tick();
    chk("rst_csa", 64'(csa_reset), 64'd1);
    chk("rst_sample", 64'(sample), 64'd0);
    chk("rst_valid", 64'(evt_if.event_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    reset_n = 1'b1;
    chk("rel_csa0", 64'(csa_reset), 64'd1);
    tick();
    chk("rel_csa1", 64'(csa_reset), 64'd1);
    tick();
    chk("rel_csa2", 64'(csa_reset), 64'd0);
    tick();

    // Single event from the vector table.
    timestamp = 24'h000100;
    dout = 10'h2A5;
    for (int k = 0; k < 20; k++) begin
      hit  = tbl[k].hit;
      done = tbl[k].done;
      tick();
      chk($sformatf("t1_sample[%0d]", k), 64'(sample), 64'(tbl[k].exp_sample));
      chk($sformatf("t1_csa[%0d]", k), 64'(csa_reset), 64'(tbl[k].exp_csa));
      chk($sformatf("t1_valid[%0d]", k), 64'(evt_if.event_valid), 64'(tbl[k].exp_valid));
      chk($sformatf("t1_count[%0d]", k), 64'(fifo_count), 64'(tbl[k].exp_count));
    end
    chk("t1_data", 64'(evt_if.event_data), 64'({24'h000100, 10'h2A5}));
    evt_if.event_ready = 1'b1;
    tick();
    evt_if.event_ready = 1'b0;
    chk("t1_pop_valid", 64'(evt_if.event_valid), 64'd0);
    chk("t1_pop_count", 64'(fifo_count), 64'd0);

    // Conversion timeout: done never arrives.
    timestamp = 24'h000400;
    fire_hit();
    wait_sig(0, 1'b1, "tmo_sample_rise");
    wait_sig(0, 1'b0, "tmo_sample_fall");
    n = 0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_latency", 64'(n), 64'd64);
    chk("tmo_no_push", 64'(fifo_count), 64'd0);
    chk("tmo_csa", 64'(csa_reset), 64'd1);
    tick();
    tick();
    chk("tmo_idle_csa", 64'(csa_reset), 64'd0);
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("tmo_clear", 64'(timeout_err), 64'd0);

    // Masked channel ignores hits and holds the CSA in reset.
    enable = 1'b0;
    tick();
    chk("mask_csa", 64'(csa_reset), 64'd1);
    hit = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) hit = 1'b0;
      tick();
      chk($sformatf("mask_sample[%0d]", i), 64'(sample), 64'd0);
      chk($sformatf("mask_csa[%0d]", i), 64'(csa_reset), 64'd1);
    end
    chk("mask_count", 64'(fifo_count), 64'd0);
    enable = 1'b1;
    tick();
    chk("unmask_csa0", 64'(csa_reset), 64'd1);
    tick();
    chk("unmask_csa1", 64'(csa_reset), 64'd1);
    tick();
    chk("unmask_csa2", 64'(csa_reset), 64'd0);
    tick();
    chk("unmask_csa3", 64'(csa_reset), 64'd0);

    // Overflow: five events into a four-deep FIFO with no consumer.
    for (int i = 0; i < 5; i++) begin
      run_event(24'h000200 + 24'(i), 10'h100 + 10'(i), 1'b0);
      if (i < 4) exp_words[i] = {24'h000200 + 24'(i), 10'h100 + 10'(i)};
    end
    chk("ovf_count", 64'(fifo_count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    drain("ovf_drain");
    chk("ovf_sticky", 64'(overflow), 64'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("ovf_clear", 64'(overflow), 64'd0);

    // Full FIFO with a pop in the same cycle as the store.
    for (int i = 0; i < 4; i++) begin
      run_event(24'h000300 + 24'(i), 10'h1C0 + 10'(i), 1'b0);
    end
    run_event(24'h0003FF, 10'h3AA, 1'b1);
    chk("fp_count", 64'(fifo_count), 64'd4);
    chk("fp_ovf", 64'(overflow), 64'd0);
    exp_words[0] = {24'h000301, 10'h1C1};
    exp_words[1] = {24'h000302, 10'h1C2};
    exp_words[2] = {24'h000303, 10'h1C3};
    exp_words[3] = {24'h0003FF, 10'h3AA};
    drain("fp_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
